hazard_ctrl: RTL

Pipeline hazard controller for the five-stage MIPS core. Compares register addresses and Tuse/Tnew values across the D/E/M/W stages to drive the datapath's `StallF`, `StallD`, `FlushE` and all `Forward_*_Sel` inputs. Also owns the multiply/divide busy sequencer and a saturating stall-cycle counter. Sits beside the datapath in the cpu top level; its outputs connect directly to the datapath's control ports of the same names.

---
 rtl/hazard_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the five-stage MIPS core.
// Resolves data stalls from Tuse/Tnew, selects forwarding sources for the
// D/E/M stages, sequences mult/div busy time, and counts stall cycles.
module hazard_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [4:0]  RsD,
    input  logic [4:0]  RtD,
    input  logic [1:0]  TuseRsD,
    input  logic [1:0]  TuseRtD,
    input  logic [4:0]  RsE,
    input  logic [4:0]  RtE,
    input  logic [4:0]  RtM,
    input  logic [4:0]  A3E,
    input  logic [4:0]  A3M,
    input  logic [4:0]  A3W,
    input  logic [1:0]  TnewE,
    input  logic [1:0]  TnewM,
    input  logic        MDStartE,
    input  logic        MDDivE,
    input  logic        MDUseD,
    output logic        StallF,
    output logic        StallD,
    output logic        FlushE,
    output logic [2:0]  Forward_RS_D_Sel,
    output logic [2:0]  Forward_RT_D_Sel,
    output logic [2:0]  Forward_RS_E_Sel,
    output logic [2:0]  Forward_RT_E_Sel,
    output logic [2:0]  Forward_RT_M_Sel,
    output logic        MDBusy,
    output logic [31:0] StallCount
);

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    logic [3:0] md_cnt;
    logic       rs_d_e, rs_d_m, rs_d_w;
    logic       rt_d_e, rt_d_m, rt_d_w;
    logic       rs_e_m, rs_e_w, rt_e_m, rt_e_w;
    logic       rt_m_w;
    logic       data_stall;
    logic       md_stall;
    logic       stall;

    // Register 0 is hard-wired, so it never counts as a producer/consumer match.
    function automatic logic hit(input logic [4:0] src, input logic [4:0] dst);
        return (src != '0) && (src == dst);
    endfunction

    // Source-vs-destination match terms for every stage pair used below.
    always_comb begin
        rs_d_e = hit(RsD, A3E);
        rs_d_m = hit(RsD, A3M);
        rs_d_w = hit(RsD, A3W);
        rt_d_e = hit(RtD, A3E);
        rt_d_m = hit(RtD, A3M);
        rt_d_w = hit(RtD, A3W);
        rs_e_m = hit(RsE, A3M);
        rs_e_w = hit(RsE, A3W);
        rt_e_m = hit(RtE, A3M);
        rt_e_w = hit(RtE, A3W);
        rt_m_w = hit(RtM, A3W);
    end

    // Stall decision: data hazards where the consumer needs a value sooner
    // than the producer can supply it, plus mult/div unit contention.
    always_comb begin
        data_stall = (rs_d_e && (TuseRsD < TnewE)) || (rs_d_m && (TuseRsD < TnewM))
                  || (rt_d_e && (TuseRtD < TnewE)) || (rt_d_m && (TuseRtD < TnewM));
        md_stall   = MDUseD && (MDBusy || MDStartE);
        stall      = Reset && (data_stall || md_stall);
        StallF     = stall;
        StallD     = stall;
        FlushE     = stall;
    end

    // Forwarding selects, nearest ready producer first; all zero in reset.
    always_comb begin
        Forward_RS_D_Sel = 3'd0;
        Forward_RT_D_Sel = 3'd0;
        Forward_RS_E_Sel = 3'd0;
        Forward_RT_E_Sel = 3'd0;
        Forward_RT_M_Sel = 3'd0;
        if (Reset) begin
            if (rs_d_e && (TnewE == 2'd0))      Forward_RS_D_Sel = 3'd1;
            else if (rs_d_m && (TnewM == 2'd0)) Forward_RS_D_Sel = 3'd2;
            else if (rs_d_w)                    Forward_RS_D_Sel = 3'd3;

            if (rt_d_e && (TnewE == 2'd0))      Forward_RT_D_Sel = 3'd1;
            else if (rt_d_m && (TnewM == 2'd0)) Forward_RT_D_Sel = 3'd2;
            else if (rt_d_w)                    Forward_RT_D_Sel = 3'd3;

            if (rs_e_m && (TnewM == 2'd0))      Forward_RS_E_Sel = 3'd1;
            else if (rs_e_w)                    Forward_RS_E_Sel = 3'd2;

            if (rt_e_m && (TnewM == 2'd0))      Forward_RT_E_Sel = 3'd1;
            else if (rt_e_w)                    Forward_RT_E_Sel = 3'd2;

            if (rt_m_w)                         Forward_RT_M_Sel = 3'd1;
        end
    end

    // Mult/div busy counter: a new start always reloads, otherwise count down to 0.
    always_ff @(posedge Clk) begin
        if (!Reset)
            md_cnt <= '0;
        else if (MDStartE)
            md_cnt <= MDDivE ? DIV_LOAD : MULT_LOAD;
        else if (md_cnt != '0)
            md_cnt <= md_cnt - 4'd1;
    end

    assign MDBusy = (md_cnt != '0);

    // Saturating count of stalled cycles since reset.
    always_ff @(posedge Clk) begin
        if (!Reset)
            StallCount <= '0;
        else if (stall && (StallCount != '1))
            StallCount <= StallCount + 32'd1;
    end

endmodule
